mp3_sdi_shifter: RTL and testbench

//  Downstream stage of the mp3 DMA engine. Serialises bytes from md_din/md_start onto the

---
 rtl/mp3_sdi_shifter.sv | 108 ++++++++++
 tb/tb_mp3_sdi_shifter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mp3_sdi_shifter.sv
// SDI serialiser for the mp3 decoder: shifts one byte per md_start out on mp3_clk/mp3_dat/mp3_bsync,
// paces the DMA through md_rdy and synchronises the decoder's asynchronous DREQ pin.
module mp3_sdi_shifter #(
  parameter int DIV       = 2,
  parameter int MSB_FIRST = 1,
  parameter int BSYNC_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] md_din,
  input  logic       md_start,
  output logic       md_rdy,
  output logic       md_dreq,
  input  logic       mp3_dreq,
  output logic       mp3_clk,
  output logic       mp3_dat,
  output logic       mp3_bsync
);

  localparam int DW = $clog2(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic [7:0]    sh_d;
  logic          clk_q, dat_q, bsync_q, rdy_q;
  logic          sync1_q, sync2_q;

  function automatic logic lead_bit(input logic [7:0] b);
    return (MSB_FIRST != 0) ? b[7] : b[0];
  endfunction

  // The bit on the wire always sits at the leading end of the shift register.
  always_comb begin
    sh_d = (MSB_FIRST != 0) ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      clk_q   <= 1'b0;
      dat_q   <= 1'b0;
      bsync_q <= 1'b0;
      rdy_q   <= 1'b1;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mp3_dreq;
      sync2_q <= sync1_q;
      case (state_q)
        IDLE: begin
          if (md_start) begin
            sh_q    <= md_din;
            dat_q   <= lead_bit(md_din);
            bsync_q <= (BSYNC_EN != 0);
            bit_q   <= '0;
            div_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            clk_q   <= 1'b1;
            state_q <= HIGH;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        HIGH: begin
          if (div_q == DIV_LAST) begin
            // Falling edge: data and bsync only ever change here.
            div_q   <= '0;
            clk_q   <= 1'b0;
            bsync_q <= 1'b0;
            if (bit_q == 3'd7) begin
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              sh_q    <= sh_d;
              dat_q   <= lead_bit(sh_d);
              bit_q   <= bit_q + 3'd1;
              state_q <= LOW;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_rdy    = rdy_q;
  assign md_dreq   = sync2_q;
  assign mp3_clk   = clk_q;
  assign mp3_dat   = dat_q;
  assign mp3_bsync = bsync_q;

endmodule

// File: tb/tb_mp3_sdi_shifter.sv
// Bench for mp3_sdi_shifter: two instances (DIV=2 MSB-first with bsync, DIV=3 LSB-first without bsync)
// checked against a byte-level model of the SDI waveform.
module tb_mp3_sdi_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       mp3_dreq;
  logic       start0, start1;
  logic [7:0] din0, din1;
  logic       rdy0, dreq0, mclk0, dat0, bs0;
  logic       rdy1, dreq1, mclk1, dat1, bs1;

  int checks = 0;
  int errors = 0;

  mp3_sdi_shifter #(.DIV(2), .MSB_FIRST(1), .BSYNC_EN(1)) u0 (
    .clk(clk), .rst(rst), .md_din(din0), .md_start(start0), .md_rdy(rdy0), .md_dreq(dreq0),
    .mp3_dreq(mp3_dreq), .mp3_clk(mclk0), .mp3_dat(dat0), .mp3_bsync(bs0));

  mp3_sdi_shifter #(.DIV(3), .MSB_FIRST(0), .BSYNC_EN(0)) u1 (
    .clk(clk), .rst(rst), .md_din(din1), .md_start(start1), .md_rdy(rdy1), .md_dreq(dreq1),
    .mp3_dreq(mp3_dreq), .mp3_clk(mclk1), .mp3_dat(dat1), .mp3_bsync(bs1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] d, input logic s);
    if (sel != 0) begin din1 = d; start1 = s; end
    else begin din0 = d; start0 = s; end
  endtask

  // {md_rdy, mp3_clk, mp3_dat, mp3_bsync}
  function automatic logic [3:0] outs(input int sel);
    return (sel != 0) ? {rdy1, mclk1, dat1, bs1} : {rdy0, mclk0, dat0, bs0};
  endfunction

  // Called at a negedge; issues md_start and watches the whole byte, returning at the
  // first negedge where md_rdy is back high so a follow-up call is back-to-back.
  task automatic send(input int sel, input logic [7:0] b, input bit spam);
    int         div   = (sel != 0) ? 3 : 2;
    bit         msb   = (sel == 0);
    bit         bsen  = (sel == 0);
    int         cnt   = 0;
    int         rises = 0;
    int         bscyc = 0;
    int         bsr   = 0;
    logic [7:0] got   = '0;
    logic [7:0] exp   = '0;
    logic       prev  = 1'b0;
    logic [3:0] o;
    for (int i = 0; i < 8; i++) exp[i] = msb ? b[7-i] : b[i];
    drive(sel, b, 1'b1);
    @(negedge clk);
    drive(sel, 8'($urandom), 1'b0);
    o = outs(sel);
    while (o[3] == 1'b0 && cnt < 1000) begin
      if (o[2] && !prev) begin
        if (rises < 8) got[rises] = o[1];
        if (o[0]) bsr++;
        rises++;
      end
      if (o[0]) bscyc++;
      prev = o[2];
      cnt++;
      if (spam) drive(sel, 8'($urandom), 1'($urandom));
      @(negedge clk);
      o = outs(sel);
    end
    drive(sel, 8'h00, 1'b0);
    chk($sformatf("busy_cycles[%0d] %02h", sel, b), cnt, 16 * div);
    chk($sformatf("rise_count[%0d] %02h", sel, b), rises, 8);
    chk($sformatf("bits[%0d] %02h", sel, b), got, exp);
    chk($sformatf("bsync_cycles[%0d] %02h", sel, b), bscyc, bsen ? 2 * div : 0);
    chk($sformatf("bsync_rises[%0d] %02h", sel, b), bsr, bsen ? 1 : 0);
    chk($sformatf("clk_low_at_done[%0d]", sel), o[2], 1'b0);
  endtask

  initial begin
    logic       hist[$];
    int         rises;
    logic       prev;
    logic [3:0] o;

    rst = 1'b1; mp3_dreq = 1'b1;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_outs0", outs(0), 4'b1000);
    chk("reset_outs1", outs(1), 4'b1000);
    chk("reset_dreq0", dreq0, 1'b0);
    chk("reset_dreq1", dreq1, 1'b0);
    rst = 1'b0; mp3_dreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outs0", outs(0), 4'b1000);

    send(0, 8'hA5, 1'b0);
    send(0, 8'h01, 1'b0);
    send(0, 8'hFF, 1'b0);
    send(0, 8'h3C, 1'b1);
    send(1, 8'h01, 1'b0);
    send(1, 8'h96, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(0, 8'($urandom), 1'b0);
      send(1, 8'($urandom), 1'b0);
    end

    // Abort a byte with reset ten edges after it was accepted.
    @(negedge clk);
    drive(0, 8'h5A, 1'b1);
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outs", {outs(0)[3], outs(0)[2], outs(0)[0]}, 3'b100);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      o = outs(0);
      if (o[2] && !prev) rises++;
      prev = o[2];
    end
    chk("midrst_no_rises", rises, 0);
    chk("midrst_rdy", outs(0)[3], 1'b1);
    send(0, 8'hC3, 1'b0);

    // DREQ synchroniser: a level driven at a negedge shows up two edges later.
    for (int i = 0; i < 16; i++) begin
      if (i >= 2) begin
        chk($sformatf("dreq0[%0d]", i), dreq0, hist[i-2]);
        chk($sformatf("dreq1[%0d]", i), dreq1, hist[i-2]);
      end
      mp3_dreq = 1'($urandom);
      hist.push_back(mp3_dreq);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
